div_unit: RTL and testbench
===========================

// Module: div_unit
// PURPOSE
//  Multi-cycle 32-bit divider in the EX stage, downstream of the ALU decoder.
//  Consumes the 8-bit alucontrol code and acts only on EXE_DIV_OP and EXE_DIVU_OP.
//  Produces {HI=remainder, LO=quotient} for the hilo register write.
//  Stalls the pipeline while the division runs.
// PARAMETERS
//  WIDTH    32  operand width; the result is 2*WIDTH bits
// PORTS
//  clk          in   1   single clock; all state changes on rising edge
//  rst          in   1   synchronous, active-high reset
//  alucontrolE  in   8   decoded ALU op in EX; starts a division when EXE_DIV_OP or EXE_DIVU_OP
//  srca         in   32  dividend (rs)
//  srcb         in   32  divisor (rt)
//  flushE       in   1   annul: abandons the division in flight, no result
//  stall_div    out  1   holds IF/ID/EX while the division is busy
//  div_ready    out  1   one-cycle pulse; div_result valid in this cycle
//  div_result   out  64  {remainder[63:32], quotient[31:0]}
// BEHAVIOUR
//  - Reset: state=IDLE, stall_div=0, div_ready=0, div_result=0, internal registers=0.
//  - start = (alucontrolE==EXE_DIV_OP || alucontrolE==EXE_DIVU_OP) & state==IDLE & ~flushE.
//  - FSM states:
//    - IDLE: on start, latch operands and signedness.
//      - Go to DIV_ZERO if srcb==0, else DIV_ON.
//    - DIV_ON: one restoring shift-subtract step per cycle; 6-bit cnt from 0.
//      - At cnt==31 the step completes, then go to DIV_END.
//    - DIV_ZERO: one cycle, then go to DIV_END. Result is forced to 64'h0.
//    - DIV_END: div_ready=1, div_result valid, stall_div=0, then go to IDLE.
//  - Timing, start sampled at cycle N:
//    - Normal: DIV_ON for N+1..N+32, DIV_END at N+33, IDLE at N+34.
//    - Divide by zero: DIV_ZERO at N+1, DIV_END at N+2.
//  - stall_div is combinational: 1 when start, or when state is DIV_ON or DIV_ZERO. It is 0 in DIV_END.
//  - Because the pipeline is frozen, alucontrolE is still DIV in DIV_END. No restart fires because state!=IDLE.
//    The pipeline advances on the edge after DIV_END.
//  - Signed (DIV):
//    - Divide |srca| by |srcb|.
//    - Negate the quotient when srca[31]^srcb[31].
//    - The remainder takes the sign of srca.
//    - 0x80000000/-1 gives q=0x80000000, r=0; no trap.
//  - Unsigned (DIVU): operands are used raw.
//  - div_result is registered and holds its last value outside DIV_END. Consumers gate on div_ready.
//  - flushE in any non-IDLE state: IDLE on the next edge, no div_ready pulse.
//    flushE on a start cycle suppresses the start.
//  - rst overrides everything at any cycle, mid-division included.
//  - Operands are sampled only at start; changes to srca/srcb during busy cycles are ignored.
// STRUCTURE
//  - EXE_DIV_OP/EXE_DIVU_OP come from defines.vh.
//  - Add to defines.vh: DIV_IDLE, DIV_ON, DIV_ZERO, DIV_END (2-bit state encodings).
//  - One sub-module, div_step: combinational restoring step.
//    - Input: {partial_rem, quotient} and the divisor.
//    - Output: the next {partial_rem, quotient}.
//  - The FSM, counter, sign fix-up and result register live in div_unit.
// TESTING
//  - DIV 100/7: q=0x0000000E, r=0x00000002; ready at N+33; stall high N..N+32.
//  - DIV -100/7: q=0xFFFFFFF2, r=0xFFFFFFFE. DIV 100/-7: q=0xFFFFFFF2, r=0x00000002.
//  - DIVU 0xFFFFFFFF/2: q=0x7FFFFFFF, r=1. DIV 0x80000000/0xFFFFFFFF: q=0x80000000, r=0.
//  - Divisor 0: div_result=64'h0, ready at N+2, stall high N..N+1 only.
//  - flushE at N+10: IDLE at N+11, no ready pulse.
//    A new DIV at N+12 completes normally at N+45.
//  - rst at N+5: all outputs 0 next cycle. Non-div ops (e.g. ADD) never raise stall_div or div_ready.

Source files
------------

// File: rtl/div_unit_pkg.sv
// Shared opcodes and FSM state encodings for the EX-stage divider.
package div_unit_pkg;

  localparam logic [7:0] EXE_DIV_OP  = 8'b00011010;
  localparam logic [7:0] EXE_DIVU_OP = 8'b00011011;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'b00,
    DIV_ON   = 2'b01,
    DIV_ZERO = 2'b10,
    DIV_END  = 2'b11
  } div_state_t;

endpackage

// File: rtl/div_unit_step.sv
// One restoring shift-subtract step on a {partial_rem, quotient} accumulator.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   divisor,
  output logic [2*WIDTH-1:0] acc_next
);

  // Partial remainder after the shift; one extra bit because the shift can carry past WIDTH.
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] rem_sub;

  // Shift in the next dividend bit, subtract when it fits, record the quotient bit.
  always_comb begin
    rem_sh  = acc[2*WIDTH-1:WIDTH-1];
    rem_sub = rem_sh[WIDTH-1:0] - divisor;
    if (rem_sh >= {1'b0, divisor}) begin
      acc_next = {rem_sub, acc[WIDTH-2:0], 1'b1};
    end else begin
      acc_next = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle signed/unsigned divider; stalls the pipeline until {rem, quo} is ready.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           alucontrolE,
  input  logic [WIDTH-1:0]     srca,
  input  logic [WIDTH-1:0]     srcb,
  input  logic                 flushE,
  output logic                 stall_div,
  output logic                 div_ready,
  output logic [2*WIDTH-1:0]   div_result
);

  localparam logic [5:0] LAST_STEP = 6'(WIDTH - 1);

  div_state_t state, state_next;
  logic [5:0]           cnt;
  logic [2*WIDTH-1:0]   acc, acc_next;
  logic [WIDTH-1:0]     divisor;
  logic                 neg_q, neg_r;
  logic                 is_div, is_signed_op, start;
  logic signed [WIDTH-1:0] srca_s, srcb_s;

  // Magnitude of an operand; unsigned ops pass through untouched.
  // The most negative value maps onto itself, which is the correct unsigned magnitude.
  function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] x,
                                                 input logic sgn);
    logic [WIDTH-1:0] m;
    m = (sgn && x[WIDTH-1]) ? -x : x;
    return m;
  endfunction

  // Sign correction: quotient negated on sign mismatch, remainder follows the dividend.
  function automatic logic [2*WIDTH-1:0] fixup(input logic [2*WIDTH-1:0] raw,
                                               input logic nq, input logic nr);
    logic [WIDTH-1:0] q, r;
    q = raw[WIDTH-1:0];
    r = raw[2*WIDTH-1:WIDTH];
    if (nq) q = -q;
    if (nr) r = -r;
    return {r, q};
  endfunction

  assign srca_s       = srca;
  assign srcb_s       = srcb;
  assign is_signed_op = (alucontrolE == EXE_DIV_OP);
  assign is_div       = is_signed_op || (alucontrolE == EXE_DIVU_OP);
  assign start        = is_div && (state == DIV_IDLE) && !flushE;

  div_step #(.WIDTH(WIDTH)) u_step (
    .acc      (acc),
    .divisor  (divisor),
    .acc_next (acc_next)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= DIV_IDLE;
    else     state <= state_next;
  end

  // Next-state logic; a flush abandons any division in flight.
  always_comb begin
    state_next = state;
    if (state != DIV_IDLE && flushE) begin
      state_next = DIV_IDLE;
    end else begin
      case (state)
        DIV_IDLE: if (start) state_next = (srcb == '0) ? DIV_ZERO : DIV_ON;
        DIV_ON:   if (cnt == LAST_STEP) state_next = DIV_END;
        DIV_ZERO: state_next = DIV_END;
        default:  state_next = DIV_IDLE;
      endcase
    end
  end

  // Outputs: stall covers the start cycle and every busy cycle, but not the result cycle.
  always_comb begin
    stall_div = start || (state == DIV_ON) || (state == DIV_ZERO);
    div_ready = (state == DIV_END);
  end

  // Datapath: operand capture at start, one step per busy cycle, result captured on the last step.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      acc        <= '0;
      divisor    <= '0;
      neg_q      <= 1'b0;
      neg_r      <= 1'b0;
      div_result <= '0;
    end else begin
      case (state)
        DIV_IDLE: begin
          if (start) begin
            acc     <= {{WIDTH{1'b0}}, magnitude(srca_s, is_signed_op)};
            divisor <= magnitude(srcb_s, is_signed_op);
            neg_q   <= is_signed_op && (srca[WIDTH-1] ^ srcb[WIDTH-1]);
            neg_r   <= is_signed_op && srca[WIDTH-1];
            cnt     <= '0;
          end
        end
        DIV_ON: begin
          if (!flushE) begin
            acc <= acc_next;
            cnt <= cnt + 6'd1;
            if (cnt == LAST_STEP) div_result <= fixup(acc_next, neg_q, neg_r);
          end
        end
        DIV_ZERO: begin
          if (!flushE) div_result <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Bench for div_unit: directed corner cases plus randomized DIV/DIVU against an arithmetic model.
module tb_div_unit;
  import div_unit_pkg::*;

  localparam logic [7:0] ADD_OP = 8'b00100000;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  alucontrolE;
  logic [31:0] srca, srcb;
  logic        flushE;
  logic        stall_div, div_ready;
  logic [63:0] div_result;

  int n_tests = 0;
  int n_fail  = 0;

  div_unit #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .alucontrolE(alucontrolE),
    .srca       (srca),
    .srcb       (srcb),
    .flushE     (flushE),
    .stall_div  (stall_div),
    .div_ready  (div_ready),
    .div_result (div_result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: native SV integer division (truncating, remainder follows dividend).
  function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a,
                                          input logic [31:0] b);
    int sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (!sgn) return {a % b, a / b};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
    sa = a;
    sb = b;
    q  = sa / sb;
    r  = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // Called just after a rising edge; that cycle is the start cycle N.
  task automatic run_div(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                         input string tag);
    int lat, bad_stall, exp_lat;
    logic got;
    logic [63:0] exp;
    exp     = ref_div(op == EXE_DIV_OP, a, b);
    exp_lat = (b == 32'd0) ? 2 : 33;
    alucontrolE = op;
    srca = a;
    srcb = b;
    @(negedge clk);
    check({tag, "/stall_start"}, 64'(stall_div), 64'd1);
    lat = 0;
    got = 1'b0;
    bad_stall = 0;
    while (!got && lat < 60) begin
      @(posedge clk);
      #1;
      srca = $urandom;
      srcb = $urandom;
      @(negedge clk);
      lat++;
      if (div_ready) got = 1'b1;
      else if (!stall_div) bad_stall++;
    end
    check({tag, "/latency"}, 64'(lat), 64'(exp_lat));
    check({tag, "/result"}, div_result, exp);
    check({tag, "/stall_end"}, 64'(stall_div), 64'd0);
    check({tag, "/stall_busy"}, 64'(bad_stall), 64'd0);
    @(posedge clk);
    #1;
    alucontrolE = ADD_OP;
    @(negedge clk);
    check({tag, "/ready_pulse"}, 64'(div_ready), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int seen;
    logic [31:0] a, b;
    logic [7:0]  op;
    rst = 1'b1;
    alucontrolE = ADD_OP;
    srca = '0;
    srcb = '0;
    flushE = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset/stall", 64'(stall_div), 64'd0);
    check("reset/ready", 64'(div_ready), 64'd0);
    check("reset/result", div_result, 64'd0);

    // Non-divide ops never stall or pulse ready.
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      srca = $urandom;
      srcb = $urandom;
      @(negedge clk);
      if (stall_div || div_ready) seen++;
    end
    check("add/no_activity", 64'(seen), 64'd0);
    @(posedge clk);
    #1;

    run_div(EXE_DIV_OP,  32'd100,       32'd7,         "div_100_7");
    run_div(EXE_DIV_OP,  -32'sd100,     32'd7,         "div_m100_7");
    run_div(EXE_DIV_OP,  32'd100,       -32'sd7,       "div_100_m7");
    run_div(EXE_DIVU_OP, 32'hFFFF_FFFF, 32'd2,         "divu_max_2");
    run_div(EXE_DIV_OP,  32'h8000_0000, 32'hFFFF_FFFF, "div_min_m1");
    run_div(EXE_DIV_OP,  32'd12345,     32'd0,         "div_by_zero");
    run_div(EXE_DIVU_OP, 32'd7,         32'd100,       "divu_small");

    // Flush on the start cycle suppresses the division.
    alucontrolE = EXE_DIV_OP;
    srca = 32'd50;
    srcb = 32'd5;
    flushE = 1'b1;
    @(negedge clk);
    check("flush_start/stall", 64'(stall_div), 64'd0);
    @(posedge clk);
    #1;
    flushE = 1'b0;
    alucontrolE = ADD_OP;
    @(negedge clk);
    check("flush_start/idle", 64'(stall_div), 64'd0);
    @(posedge clk);
    #1;

    // Flush mid-division at N+10: idle at N+11, no ready; new divide at N+12 runs normally.
    alucontrolE = EXE_DIV_OP;
    srca = 32'd1000;
    srcb = 32'd3;
    seen = 0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      #1;
      if (k == 10) flushE = 1'b1;
      @(negedge clk);
      if (div_ready) seen++;
    end
    @(posedge clk);
    #1;
    flushE = 1'b0;
    alucontrolE = ADD_OP;
    @(negedge clk);
    if (div_ready) seen++;
    check("flush_mid/no_ready", 64'(seen), 64'd0);
    check("flush_mid/idle", 64'(stall_div), 64'd0);
    @(posedge clk);
    #1;
    run_div(EXE_DIV_OP, -32'sd999, 32'd13, "after_flush");

    // Reset at N+5 clears everything by the next cycle.
    alucontrolE = EXE_DIV_OP;
    srca = 32'd500;
    srcb = 32'd9;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    alucontrolE = ADD_OP;
    @(negedge clk);
    check("mid_reset/stall", 64'(stall_div), 64'd0);
    check("mid_reset/ready", 64'(div_ready), 64'd0);
    check("mid_reset/result", div_result, 64'd0);
    @(posedge clk);
    #1;

    // Randomized operands, mixing signedness, zero divisors and small divisors.
    for (int i = 0; i < 24; i++) begin
      op = ($urandom_range(0, 1) == 0) ? EXE_DIV_OP : EXE_DIVU_OP;
      a  = $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1, 2:    b = $urandom_range(1, 20);
        3:       b = -($urandom_range(1, 20));
        default: b = $urandom;
      endcase
      run_div(op, a, b, $sformatf("rand%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
